// File: rtl/bf_io_uart_pkg.sv
// Shared types for the bfcpu I/O-port UART bridge.
// Direction codes and 2-bit state encodings for the port, TX and RX FSMs.
package bf_io_uart_pkg;

   localparam logic DIRECTION_READ  = 1'b0;
   localparam logic DIRECTION_WRITE = 1'b1;

   typedef enum logic [1:0] {
      P_IDLE    = 2'd0,
      P_WR_WAIT = 2'd1,
      P_RD_WAIT = 2'd2,
      P_ACK     = 2'd3
   } port_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/bf_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head.
// A pop in the same cycle as a push frees room, so a push into a full FIFO is kept.
module bf_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_pop};
      count_d  = count_q + {{AW{1'b0}}, do_push}
                         - {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/bf_io_uart.sv
// bfcpu I/O-port peripheral bridging io_req/io_ack to an 8N1 UART with RX FIFO.
// Define BF_IO_UART_LOOPBACK_EN to feed uart_txd back into the receiver.
module bf_io_uart
   import bf_io_uart_pkg::*;
#(
   parameter logic [15:0] CLK_DIV    = 16'd868,
   parameter int          RX_FIFO_AW = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       io_req,
   input  logic       io_dir,
   input  logic [7:0] io_wdata,
   output logic       io_ack,
   output logic [7:0] io_rdata,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic       rx_overrun
);

   localparam logic [15:0] DIV_M1  = CLK_DIV - 16'd1;
   localparam logic [15:0] HALF_M1 = (CLK_DIV >> 1) - 16'd1;

   port_state_t port_q, port_d;
   logic        ack_q, ack_d;
   logic [7:0]  rdata_q, rdata_d;

   tx_state_t   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        txd_q, txd_d;
   logic        tx_tick, tx_ready, tx_load;

   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   logic        overrun_q, overrun_d;
   logic        rx_in, rx_tick, rx_fall, rx_frame_ok;

   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_head;

`ifdef BF_IO_UART_LOOPBACK_EN
   logic unused_rxd;
   assign unused_rxd = uart_rxd;
   assign rx_in      = txd_q;
`else
   assign rx_in      = uart_rxd;
`endif

   assign io_ack     = ack_q;
   assign io_rdata   = rdata_q;
   assign uart_txd   = txd_q;
   assign rx_overrun = overrun_q;

   // Last stop-bit clock counts as ready so back-to-back frames abut.
   assign tx_tick  = (tx_cnt_q == '0);
   assign tx_ready = (tx_state_q == TX_IDLE)
                  || (tx_state_q == TX_STOP && tx_tick);

   always_comb begin
      port_d   = port_q;
      ack_d    = ack_q;
      rdata_d  = rdata_q;
      fifo_pop = 1'b0;
      tx_load  = 1'b0;
      unique case (port_q)
         P_IDLE: begin
            if (io_req && !ack_q)
               port_d = (io_dir == DIRECTION_WRITE) ? P_WR_WAIT : P_RD_WAIT;
         end
         P_WR_WAIT: begin
            if (tx_ready) begin
               tx_load = 1'b1;
               ack_d   = 1'b1;
               port_d  = P_ACK;
            end
         end
         P_RD_WAIT: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               rdata_d  = fifo_head;
               ack_d    = 1'b1;
               port_d   = P_ACK;
            end
         end
         P_ACK: begin
            if (!io_req) begin
               ack_d  = 1'b0;
               port_d = P_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      if (tx_state_q != TX_IDLE && !tx_tick) tx_cnt_d = tx_cnt_q - 16'd1;
      unique case (tx_state_q)
         TX_IDLE: txd_d = 1'b1;
         TX_START: begin
            if (tx_tick) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = DIV_M1;
               tx_bit_d   = 3'd0;
               txd_d      = tx_shift_q[0];
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
            end
         end
         TX_DATA: begin
            if (tx_tick) begin
               tx_cnt_d = DIV_M1;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  txd_d      = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  txd_d      = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end
         end
         TX_STOP: begin
            if (tx_tick) tx_state_d = TX_IDLE;
         end
      endcase
      if (tx_load) begin
         tx_state_d = TX_START;
         tx_cnt_d   = DIV_M1;
         tx_shift_d = io_wdata;
         txd_d      = 1'b0;
      end
   end

   assign rx_tick = (rx_cnt_q == '0);
   assign rx_fall = rx_prev_q && !rx_s2_q;

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_frame_ok = 1'b0;
      if (rx_state_q != RX_IDLE && !rx_tick) rx_cnt_d = rx_cnt_q - 16'd1;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (rx_fall) begin
               rx_state_d = RX_START;
               rx_cnt_d   = HALF_M1;
            end
         end
         RX_START: begin
            if (rx_tick) begin
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
               rx_cnt_d   = DIV_M1;
               rx_bit_d   = 3'd0;
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_cnt_d   = DIV_M1;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               rx_state_d  = RX_IDLE;
               rx_frame_ok = rx_s2_q;
            end
         end
      endcase
   end

   always_comb begin
      fifo_push = rx_frame_ok && (!fifo_full || fifo_pop);
      overrun_d = overrun_q || (rx_frame_ok && fifo_full && !fifo_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         port_q     <= P_IDLE;
         ack_q      <= 1'b0;
         rdata_q    <= 8'h00;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         overrun_q  <= 1'b0;
      end else begin
         port_q     <= port_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_s1_q    <= rx_in;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         overrun_q  <= overrun_d;
      end
   end

   bf_sync_fifo #(
      .WIDTH (8),
      .AW    (RX_FIFO_AW)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (rx_shift_q),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

endmodule

// File: tb/tb_bf_io_uart.sv
// Bench for bf_io_uart at CLK_DIV=4, RX_FIFO_AW=2: directed frames, RX vector table,
// and a random mix of reads/writes/frames checked against a queue-based model.
module tb_bf_io_uart;

   localparam logic [15:0] DIV   = 16'd4;
   localparam int          AW    = 2;
   localparam int          DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       io_req = 1'b0;
   logic       io_dir = 1'b0;
   logic [7:0] io_wdata = 8'h00;
   logic       io_ack;
   logic [7:0] io_rdata;
   logic       uart_rxd = 1'b1;
   logic       uart_txd;
   logic       rx_overrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] tx_got [$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_push;
   } rx_vec_t;

   bf_io_uart #(
      .CLK_DIV    (DIV),
      .RX_FIFO_AW (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .io_req     (io_req),
      .io_dir     (io_dir),
      .io_wdata   (io_wdata),
      .io_ack     (io_ack),
      .io_rdata   (io_rdata),
      .uart_rxd   (uart_rxd),
      .uart_txd   (uart_txd),
      .rx_overrun (rx_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act,
                              input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Serial frame as seen on the wire: start, 8 data LSB first, stop.
   function automatic logic frame_bit(input logic [7:0] d, input int k);
      logic [9:0] f;
      f = {1'b1, d, 1'b0};
      if (k < 0 || k >= 40) return 1'b1;
      return f[k/4];
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      io_req = 1'b0;
      uart_rxd = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(2);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input int gap);
      uart_rxd = 1'b0;
      cyc(4);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = d[i];
         cyc(4);
      end
      uart_rxd = stop;
      cyc(4);
      uart_rxd = 1'b1;
      cyc(gap);
   endtask

   task automatic release_req(input string name);
      io_req = 1'b0;
      cyc(1);
      check(name, io_ack, 1'b0);
   endtask

   task automatic do_read(output logic [7:0] d, output bit ok,
                          input int limit);
      ok = 1'b0;
      d = 8'h00;
      io_dir = 1'b0;
      io_req = 1'b1;
      for (int i = 0; i < limit && !ok; i++) begin
         cyc(1);
         if (io_ack) begin
            ok = 1'b1;
            d = io_rdata;
         end
      end
      if (ok) release_req("rd_ack_release");
      else io_req = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] d, output bit ok,
                           input int limit);
      ok = 1'b0;
      io_dir = 1'b1;
      io_wdata = d;
      io_req = 1'b1;
      for (int i = 0; i < limit && !ok; i++) begin
         cyc(1);
         if (io_ack) ok = 1'b1;
      end
      if (ok) release_req("wr_ack_release");
      else io_req = 1'b0;
   endtask

   // Independent UART receiver on uart_txd, sampling mid-bit.
   initial begin
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      b = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) prev = 1'b1;
         else begin
            if (prev && !uart_txd) begin
               repeat (2) @(negedge clk);
               for (int i = 0; i < 8; i++) begin
                  repeat (4) @(negedge clk);
                  b[i] = uart_txd;
               end
               repeat (4) @(negedge clk);
               if (uart_txd) tx_got.push_back(b);
            end
            prev = uart_txd;
         end
      end
   end

   initial begin
      int         ack_at;
      int         nwr;
      int         lows;
      int         ack_idx [$];
      logic [7:0] got;
      bit         ok;
      logic       exp_bit;
      rx_vec_t    rx_tab [8];
      logic [7:0] rx_model [$];
      logic [7:0] tx_exp [$];
      logic       exp_ovr;

      rx_tab = '{
         '{8'h3C, 1'b1, 1'b1}, '{8'h7E, 1'b0, 1'b0},
         '{8'hFF, 1'b1, 1'b1}, '{8'h00, 1'b1, 1'b1},
         '{8'hA5, 1'b0, 1'b0}, '{8'h81, 1'b1, 1'b1},
         '{8'h5A, 1'b0, 1'b0}, '{8'h01, 1'b1, 1'b1}
      };

      cyc(2);
      check("rst_ack", io_ack, 1'b0);
      check("rst_rdata", io_rdata, 8'h00);
      check("rst_txd", uart_txd, 1'b1);
      check("rst_overrun", rx_overrun, 1'b0);

      // Single write of 0x41 on an idle transmitter.
      do_reset();
      io_dir = 1'b1;
      io_wdata = 8'h41;
      io_req = 1'b1;
      ack_at = -1;
      for (int i = 1; i <= 46; i++) begin
         cyc(1);
         if (io_ack && ack_at < 0) ack_at = i;
         exp_bit = frame_bit(8'h41, i - 2);
         check($sformatf("t1_txd[%0d]", i), uart_txd, exp_bit);
         if (i == 10) begin
            check("t1_ack_held", io_ack, 1'b1);
            io_req = 1'b0;
         end
         if (i == 11) check("t1_ack_drop", io_ack, 1'b0);
      end
      check("t1_ack_cycle", ack_at, 2);

      // Back-to-back writes 0x55, 0xAA: second frame abuts first.
      do_reset();
      io_dir = 1'b1;
      io_wdata = 8'h55;
      io_req = 1'b1;
      nwr = 1;
      ack_idx.delete();
      for (int i = 1; i <= 90; i++) begin
         cyc(1);
         exp_bit = (i < 42) ? frame_bit(8'h55, i - 2)
                            : frame_bit(8'hAA, i - 42);
         check($sformatf("t2_txd[%0d]", i), uart_txd, exp_bit);
         if (io_req && io_ack) begin
            ack_idx.push_back(i);
            io_req = 1'b0;
         end else if (!io_req && !io_ack && nwr < 2) begin
            io_wdata = 8'hAA;
            io_req = 1'b1;
            nwr++;
         end
      end
      check("t2_ack_count", ack_idx.size(), 2);
      if (ack_idx.size() == 2) begin
         check("t2_ack0", ack_idx[0], 2);
         check("t2_ack1", ack_idx[1], 42);
      end

      // Reset in the middle of a data bit abandons the frame.
      do_reset();
      io_dir = 1'b1;
      io_wdata = 8'h41;
      io_req = 1'b1;
      cyc(11);
      check("t6_txd_pre", uart_txd, 1'b0);
      check("t6_ack_pre", io_ack, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("t6_txd_rst", uart_txd, 1'b1);
      check("t6_ack_rst", io_ack, 1'b0);
      io_req = 1'b0;
      cyc(2);
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 44; i++) begin
         cyc(1);
         if (!uart_txd) lows++;
      end
      check("t6_txd_idle", lows, 0);

`ifndef BF_IO_UART_LOOPBACK_EN
      // Blocking read satisfied by a frame arriving later.
      do_reset();
      io_dir = 1'b0;
      io_req = 1'b1;
      ack_at = -1;
      fork
         send_frame(8'h3C, 1'b1, 0);
         for (int i = 1; i <= 60 && ack_at < 0; i++) begin
            cyc(1);
            if (io_ack) ack_at = i;
         end
      join
      check_range("t3_ack_time", ack_at, 38, 44);
      check("t3_rdata", io_rdata, 8'h3C);
      cyc(3);
      check("t3_ack_hold", io_ack, 1'b1);
      check("t3_rdata_hold", io_rdata, 8'h3C);
      release_req("t3_ack_drop");

      // RX vector table: bad-stop frames must vanish.
      do_reset();
      foreach (rx_tab[k]) begin
         send_frame(rx_tab[k].data, rx_tab[k].stop, 3);
         if (rx_tab[k].exp_push) begin
            do_read(got, ok, 20);
            check($sformatf("tab%0d_ack", k), ok, 1'b1);
            check($sformatf("tab%0d_data", k), got, rx_tab[k].data);
         end
         check($sformatf("tab%0d_ovr", k), rx_overrun, 1'b0);
      end

      // Overflow: fifth frame into a 4-deep FIFO is dropped.
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, 3);
         check($sformatf("t4_ovr%0d", i), rx_overrun, (i == 5));
      end
      for (int i = 1; i <= 4; i++) begin
         do_read(got, ok, 20);
         check($sformatf("t4_rd%0d_ack", i), ok, 1'b1);
         check($sformatf("t4_rd%0d", i), got, 8'(i));
      end
      do_read(got, ok, 60);
      check("t4_empty", ok, 1'b0);
      check("t4_ovr_sticky", rx_overrun, 1'b1);

      // Framing error then a short glitch: nothing received.
      do_reset();
      send_frame(8'h7E, 1'b0, 3);
      uart_rxd = 1'b0;
      cyc(2);
      uart_rxd = 1'b1;
      cyc(10);
      check("t5_ovr", rx_overrun, 1'b0);
      do_read(got, ok, 60);
      check("t5_no_ack", ok, 1'b0);

      // Random mix against queue model.
      do_reset();
      cyc(50);
      tx_got.delete();
      rx_model.delete();
      tx_exp.delete();
      exp_ovr = 1'b0;
      for (int n = 0; n < 40; n++) begin
         int         op;
         logic [7:0] d;
         logic       stop;
         op = $urandom_range(0, 2);
         d = 8'($urandom);
         if (op == 0) begin
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, stop, $urandom_range(1, 5));
            if (stop) begin
               if (rx_model.size() < DEPTH) rx_model.push_back(d);
               else exp_ovr = 1'b1;
            end
            check("rnd_ovr", rx_overrun, exp_ovr);
         end else if (op == 1 && rx_model.size() > 0) begin
            do_read(got, ok, 20);
            check("rnd_rd_ack", ok, 1'b1);
            check("rnd_rd", got, rx_model.pop_front());
         end else begin
            do_write(d, ok, 60);
            check("rnd_wr_ack", ok, 1'b1);
            tx_exp.push_back(d);
         end
      end
      cyc(100);
      check("rnd_tx_count", tx_got.size(), tx_exp.size());
      foreach (tx_exp[k]) begin
         if (k < tx_got.size())
            check($sformatf("rnd_tx%0d", k), tx_got[k], tx_exp[k]);
      end
`else
      // Loopback: a written byte comes back through the receiver.
      do_reset();
      do_write(8'hC3, ok, 20);
      check("lb_wr_ack", ok, 1'b1);
      do_read(got, ok, 80);
      check("lb_rd_ack", ok, 1'b1);
      check("lb_rdata", got, 8'hC3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
